// File: rtl/regfile_bypass.sv
// Parametrised register bank: one write port, two combinational read ports, per-register busy scoreboard.
// Optional same-cycle write-to-read forwarding when REGFILE_BYPASS_EN is defined.

module regfile_bypass_cell #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_sel,
  input  logic             iss_sel,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] data,
  output logic             busy
);
  logic [WIDTH-1:0] data_q, data_d;
  logic             busy_q, busy_d;

  // A new issue outranks a writeback: the newer producer is still outstanding.
  always_comb begin
    data_d = data_q;
    busy_d = busy_q;
    if (wr_sel)  data_d = wdata;
    if (iss_sel)     busy_d = 1'b1;
    else if (wr_sel) busy_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      busy_q <= 1'b0;
    end else begin
      data_q <= data_d;
      busy_q <= busy_d;
    end
  end

  assign data = data_q;
  assign busy = busy_q;
endmodule

module regfile_bypass #(
  parameter  int WIDTH = 16,
  parameter  int NREGS = 4,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             issue,
  input  logic [AW-1:0]    issue_addr,
  input  logic [AW-1:0]    ra_addr,
  input  logic [AW-1:0]    rb_addr,
  output logic [WIDTH-1:0] ra_data,
  output logic [WIDTH-1:0] rb_data,
  output logic             ra_ready,
  output logic             rb_ready,
  output logic [NREGS-1:0] busy
);
  logic [NREGS-1:0][WIDTH-1:0] regs;

  if (NREGS < 2 || NREGS > 16 || (1 << AW) != NREGS) begin : g_bad_nregs
    $error("regfile_bypass: NREGS must be a power of two in 2..16");
  end

  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    regfile_bypass_cell #(.WIDTH(WIDTH)) u_cell (
      .clk     (clk),
      .rst     (rst),
      .wr_sel  (we && (waddr == AW'(i))),
      .iss_sel (issue && (issue_addr == AW'(i))),
      .wdata   (wdata),
      .data    (regs[i]),
      .busy    (busy[i])
    );
  end

  // Storage resets to zero and busy to clear, so reset read values fall out naturally;
  // forwarding is explicitly held off while rst is high.
  always_comb begin
    ra_data  = regs[ra_addr];
    ra_ready = ~busy[ra_addr];
    rb_data  = regs[rb_addr];
    rb_ready = ~busy[rb_addr];
`ifdef REGFILE_BYPASS_EN
    if (!rst && we && (waddr == ra_addr)) begin
      ra_data  = wdata;
      ra_ready = 1'b1;
    end
    if (!rst && we && (waddr == rb_addr)) begin
      rb_data  = wdata;
      rb_ready = 1'b1;
    end
`endif
  end
endmodule
